// File: rtl/ddr_burst_sched.sv
// ddr_burst_sched
// Shares the single DDR3 application port between the camera write FIFO and
// the HDMI read FIFO. Picks a requester from the FIFO fill levels, generates
// frame-relative burst addresses that wrap at the end of a frame, and keeps
// exactly one burst command outstanding at a time.
// Optional build macro: RD_URGENT_EN (read wins ties when the read FIFO is
// nearly empty, protecting the display from underrun).
module ddr_burst_sched #(
    parameter int ADDR_W       = 29,
    parameter int LVL_W        = 12,
    parameter int BURST_LEN    = 240,
    parameter int FRAME_WORDS  = 2073600,
    parameter int URGENT_SPACE = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic [LVL_W-1:0]  wr_fifo_level,
    input  logic [LVL_W-1:0]  rd_fifo_space,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    input  logic              burst_done,
    output logic              busy,
    output logic              wr_frame_done,
    output logic              rd_frame_done
);

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_WORDS);
    localparam logic [LVL_W-1:0]  BURST_LVL  = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]  URGENT_LVL = LVL_W'(URGENT_SPACE);
`ifdef RD_URGENT_EN
    localparam logic URGENT_EN = 1'b1;
`else
    localparam logic URGENT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic              cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic              last_rd_q, last_rd_d;
    logic              wr_done_q, wr_done_d;
    logic              rd_done_q, rd_done_d;

    logic              wr_elig, rd_elig, rd_urgent, any_elig, grant_rd;
    logic              wr_pend_now, rd_pend_now;
    logic [ADDR_W-1:0] wr_base, rd_base, wr_next, rd_next;

    // Requester selection: round-robin on ties, optionally overridden by read urgency
    always_comb begin
        wr_elig   = (wr_fifo_level >= BURST_LVL);
        rd_elig   = (rd_fifo_space >= BURST_LVL);
        rd_urgent = URGENT_EN && rd_elig && (rd_fifo_space >= URGENT_LVL);
        any_elig  = wr_elig || rd_elig;
        if (wr_elig && rd_elig) begin
            grant_rd = rd_urgent ? 1'b1 : !last_rd_q;
        end else begin
            grant_rd = rd_elig;
        end
    end

    // State register plus all datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            last_rd_q   <= 1'b1;
            wr_done_q   <= 1'b0;
            rd_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            last_rd_q   <= last_rd_d;
            wr_done_q   <= wr_done_d;
            rd_done_q   <= rd_done_d;
        end
    end

    // Next-state logic; losing calibration aborts everything back to IDLE
    always_comb begin
        state_d = state_q;
        if (!init_done) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_ARB;
                S_ARB:   if (any_elig)   state_d = S_ISSUE;
                S_ISSUE: if (cmd_ready)  state_d = S_WAIT;
                S_WAIT:  if (burst_done) state_d = S_ARB;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Pointer, frame-restart and command-field updates for the next cycle
    always_comb begin
        wr_pend_now = wr_pend_q || wr_load;
        rd_pend_now = rd_pend_q || rd_load;
        wr_base     = wr_pend_now ? '0 : wr_ptr_q;
        rd_base     = rd_pend_now ? '0 : rd_ptr_q;
        wr_next     = wr_ptr_q + STEP;
        rd_next     = rd_ptr_q + STEP;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_pend_d   = wr_pend_now;
        rd_pend_d   = rd_pend_now;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        last_rd_d   = last_rd_q;
        wr_done_d   = 1'b0;
        rd_done_d   = 1'b0;

        if (!init_done) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            wr_pend_d = 1'b0;
            rd_pend_d = 1'b0;
        end else if (state_q == S_ARB) begin
            wr_ptr_d  = wr_base;
            rd_ptr_d  = rd_base;
            wr_pend_d = 1'b0;
            rd_pend_d = 1'b0;
            if (any_elig) begin
                cmd_write_d = !grant_rd;
                cmd_addr_d  = grant_rd ? rd_base : wr_base;
                last_rd_d   = grant_rd;
            end
        end else if (state_q == S_WAIT && burst_done) begin
            if (cmd_write_q) begin
                wr_pend_d = 1'b0;
                wr_done_d = (wr_next == FRAME_END);
                wr_ptr_d  = (wr_done_d || wr_pend_now) ? '0 : wr_next;
            end else begin
                rd_pend_d = 1'b0;
                rd_done_d = (rd_next == FRAME_END);
                rd_ptr_d  = (rd_done_d || rd_pend_now) ? '0 : rd_next;
            end
        end
    end

    // Outputs decoded from registered state and fields
    always_comb begin
        cmd_valid     = (state_q == S_ISSUE);
        busy          = (state_q == S_ISSUE) || (state_q == S_WAIT);
        cmd_write     = cmd_write_q;
        cmd_addr      = cmd_addr_q;
        cmd_len       = 8'(BURST_LEN);
        wr_frame_done = wr_done_q;
        rd_frame_done = rd_done_q;
    end

endmodule
